// File: rtl/cpu_core.sv
// Multicycle MIPS-like core: FETCH -> DECODE -> EXEC (-> MEM for lw), 32-bit PC in words.
// Optional `OVF_EXCEPTION_EN: signed overflow on add/addi/sub writes a cause code to r30.
module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StMem} state_e;

  localparam logic [4:0] OpRType = 5'b00000;
  localparam logic [4:0] OpJ     = 5'b00001;
  localparam logic [4:0] OpBne   = 5'b00010;
  localparam logic [4:0] OpJal   = 5'b00011;
  localparam logic [4:0] OpJr    = 5'b00100;
  localparam logic [4:0] OpAddi  = 5'b00101;
  localparam logic [4:0] OpBlt   = 5'b00110;
  localparam logic [4:0] OpSw    = 5'b00111;
  localparam logic [4:0] OpLw    = 5'b01000;
  localparam logic [4:0] OpSetx  = 5'b10101;
  localparam logic [4:0] OpBex   = 5'b10110;

  localparam logic [4:0] AluAdd = 5'b00000;
  localparam logic [4:0] AluSub = 5'b00001;
  localparam logic [4:0] AluAnd = 5'b00010;
  localparam logic [4:0] AluOr  = 5'b00011;
  localparam logic [4:0] AluSll = 5'b00100;
  localparam logic [4:0] AluSra = 5'b00101;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [31:0] imm, target;
  logic [31:0] sum, diff, imm_sum, pc_inc, pc_br;

  assign opcode = ir_q[31:27];
  assign rd     = ir_q[26:22];
  assign rs     = ir_q[21:17];
  assign rt     = ir_q[16:12];
  assign shamt  = ir_q[11:7];
  assign aluop  = ir_q[6:2];
  assign imm    = {{15{ir_q[16]}}, ir_q[16:0]};
  assign target = {5'd0, ir_q[26:0]};

  assign sum     = data_readRegA + data_readRegB;
  assign diff    = data_readRegA - data_readRegB;
  assign imm_sum = data_readRegA + imm;
  assign pc_inc  = pc_q + 32'd1;
  assign pc_br   = pc_inc + imm;

`ifdef OVF_EXCEPTION_EN
  logic ovf_add, ovf_sub, ovf_addi;
  assign ovf_add  = (data_readRegA[31] == data_readRegB[31]) && (sum[31] != data_readRegA[31]);
  assign ovf_sub  = (data_readRegA[31] != data_readRegB[31]) && (diff[31] != data_readRegA[31]);
  assign ovf_addi = (data_readRegA[31] == imm[31]) && (imm_sum[31] != data_readRegA[31]);
`endif

  // Address stays valid through MEM since IR and the source register are unchanged.
  assign address_imem = pc_q;
  assign address_dmem = imm_sum;
  assign data         = data_readRegB;

  always_comb begin
    ctrl_readRegA = rs;
    ctrl_readRegB = rt;
    case (opcode)
      OpSw, OpJr: ctrl_readRegB = rd;
      OpBne, OpBlt: begin
        ctrl_readRegA = rd;
        ctrl_readRegB = rs;
      end
      OpBex: ctrl_readRegA = 5'd30;
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ir_d             = ir_q;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = rd;
    data_writeReg    = 32'd0;
    wren             = 1'b0;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        ir_d    = q_imem;
        state_d = StExec;
      end
      StExec: begin
        pc_d    = pc_inc;
        state_d = StFetch;
        case (opcode)
          OpRType: begin
            ctrl_writeEnable = 1'b1;
            case (aluop)
              AluAdd: begin
                data_writeReg = sum;
`ifdef OVF_EXCEPTION_EN
                if (ovf_add) begin
                  ctrl_writeReg = 5'd30;
                  data_writeReg = 32'd1;
                end
`endif
              end
              AluSub: begin
                data_writeReg = diff;
`ifdef OVF_EXCEPTION_EN
                if (ovf_sub) begin
                  ctrl_writeReg = 5'd30;
                  data_writeReg = 32'd3;
                end
`endif
              end
              AluAnd:  data_writeReg = data_readRegA & data_readRegB;
              AluOr:   data_writeReg = data_readRegA | data_readRegB;
              AluSll:  data_writeReg = data_readRegA << shamt;
              AluSra:  data_writeReg = $unsigned($signed(data_readRegA) >>> shamt);
              default: ctrl_writeEnable = 1'b0;
            endcase
          end
          OpAddi: begin
            ctrl_writeEnable = 1'b1;
            data_writeReg    = imm_sum;
`ifdef OVF_EXCEPTION_EN
            if (ovf_addi) begin
              ctrl_writeReg = 5'd30;
              data_writeReg = 32'd2;
            end
`endif
          end
          OpSw: wren = 1'b1;
          OpLw: state_d = StMem;
          OpJ:  pc_d = target;
          OpJal: begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = 5'd31;
            data_writeReg    = pc_inc;
            pc_d             = target;
          end
          OpJr:  pc_d = data_readRegB;
          OpBne: if (data_readRegA != data_readRegB) pc_d = pc_br;
          OpBlt: if ($signed(data_readRegA) < $signed(data_readRegB)) pc_d = pc_br;
          OpSetx: begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = 5'd30;
            data_writeReg    = target;
          end
          OpBex: if (data_readRegA != 32'd0) pc_d = target;
          default: ;
        endcase
      end
      StMem: begin
        ctrl_writeEnable = 1'b1;
        data_writeReg    = q_dmem;
        state_d          = StFetch;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: behavioural ROM/RAM/regfile, single-instruction vector table,
// plus hand-written multi-instruction, load/store and mid-instruction reset sequences.
module tb_cpu_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_imem, q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem;

  cpu_core #(.RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg), .data_readRegA(data_readRegA),
    .data_readRegB(data_readRegB), .wren(wren), .address_dmem(address_dmem),
    .data(data), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  logic [31:0] rom [4096];
  logic [31:0] ram [4096];
  logic [31:0] regs [32];
  logic [31:0] init_regs [32];
  logic        load_regs = 1'b0;

  always @(posedge clock) q_imem <= rom[address_imem[11:0]];

  always @(posedge clock) begin
    if (load_regs) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 32'd0;
    end else if (wren) begin
      ram[address_dmem[11:0]] <= data;
    end
    q_dmem <= ram[address_dmem[11:0]];
  end

  always @(posedge clock) begin
    if (load_regs) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'd0 : init_regs[i];
    end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : regs[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : regs[ctrl_readRegB];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int rd, int rs, int rt, int sh, int alu);
    return {5'd0, rd[4:0], rs[4:0], rt[4:0], sh[4:0], alu[4:0], 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rd, int rs, int imm);
    return {op[4:0], rd[4:0], rs[4:0], imm[16:0]};
  endfunction

  function automatic logic [31:0] enc_j(int op, int t);
    return {op[4:0], t[26:0]};
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 4096; i++) rom[i] = 32'd0;
    for (int i = 0; i < 32; i++) init_regs[i] = 32'd0;
  endtask

  // Hold reset for two cycles while the models load, release on a falling edge.
  task automatic start();
    reset     = 1'b0;
    load_regs = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    load_regs = 1'b0;
    reset     = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          ra;
    logic [31:0] va;
    int          rb;
    logic [31:0] vb;
    int          chk;
    logic [31:0] exp_val;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [31:0] ins, int ra, logic [31:0] va, int rb,
                              logic [31:0] vb, int chk, logic [31:0] ev, logic [31:0] ep);
    vec_t v;
    v.name = n; v.instr = ins; v.ra = ra; v.va = va; v.rb = rb; v.vb = vb;
    v.chk = chk; v.exp_val = ev; v.exp_pc = ep;
    return v;
  endfunction

  logic [9:0]  we_mask, wren_mask;
  logic [31:0] st_addr, st_data;

  initial begin
    vecs.push_back(mk("addi_pos", enc_i(5, 1, 0, 5), 0, 0, 0, 0, 1, 32'd5, 32'd1));
    vecs.push_back(mk("addi_neg", enc_i(5, 2, 0, -3), 0, 0, 0, 0, 2, 32'hFFFFFFFD, 32'd1));
    vecs.push_back(mk("add", enc_r(3, 1, 2, 0, 0), 1, 32'd5, 2, 32'hFFFFFFFD, 3, 32'd2, 32'd1));
    vecs.push_back(mk("sub", enc_r(3, 1, 2, 0, 1), 1, 32'd12, 2, 32'd10, 3, 32'd2, 32'd1));
    vecs.push_back(mk("and", enc_r(3, 1, 2, 0, 2), 1, 32'd12, 2, 32'd10, 3, 32'd8, 32'd1));
    vecs.push_back(mk("or", enc_r(3, 1, 2, 0, 3), 1, 32'd12, 2, 32'd10, 3, 32'd14, 32'd1));
    vecs.push_back(mk("sll", enc_r(3, 1, 0, 2, 4), 1, 32'd12, 0, 0, 3, 32'd48, 32'd1));
    vecs.push_back(mk("sra", enc_r(3, 1, 0, 2, 5), 1, 32'hFFFFFFF0, 0, 0, 3, 32'hFFFFFFFC, 32'd1));
    vecs.push_back(mk("alu_nop", enc_r(3, 1, 2, 0, 6), 1, 32'd12, 3, 32'h55, 3, 32'h55, 32'd1));
    vecs.push_back(mk("bne_tk", enc_i(2, 1, 2, 2), 1, 32'd5, 2, 32'd3, 1, 32'd5, 32'd3));
    vecs.push_back(mk("bne_nt", enc_i(2, 1, 2, 2), 1, 32'd7, 2, 32'd7, 1, 32'd7, 32'd1));
    vecs.push_back(mk("blt_tk", enc_i(6, 1, 2, 4), 1, 32'hFFFFFFFF, 2, 0, 1, 32'hFFFFFFFF, 32'd5));
    vecs.push_back(mk("blt_nt", enc_i(6, 1, 2, 4), 1, 0, 2, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 32'd1));
    vecs.push_back(mk("blt_wrap", enc_i(6, 1, 2, -2), 1, 32'hFFFFFFFF, 2, 0, 2, 0, 32'hFFFFFFFF));
    vecs.push_back(mk("j", enc_j(1, 10), 1, 32'd5, 0, 0, 1, 32'd5, 32'd10));
    vecs.push_back(mk("j_max", enc_j(1, 27'h7FFFFFF), 0, 0, 0, 0, 0, 0, 32'h07FFFFFF));
    vecs.push_back(mk("jal", enc_j(3, 10), 0, 0, 0, 0, 31, 32'd1, 32'd10));
    vecs.push_back(mk("jr", enc_i(4, 31, 0, 0), 31, 32'h20, 0, 0, 31, 32'h20, 32'h20));
    vecs.push_back(mk("setx", enc_j(21, 9), 0, 0, 0, 0, 30, 32'd9, 32'd1));
    vecs.push_back(mk("bex_tk", enc_j(22, 20), 30, 32'd9, 0, 0, 30, 32'd9, 32'd20));
    vecs.push_back(mk("bex_nt", enc_j(22, 20), 30, 0, 0, 0, 30, 0, 32'd1));
    vecs.push_back(mk("bad_op", enc_j(31, 5), 1, 32'd5, 0, 0, 1, 32'd5, 32'd1));
`ifdef OVF_EXCEPTION_EN
    vecs.push_back(mk("ovf_add", enc_r(3, 1, 2, 0, 0), 1, 32'h7FFFFFFF, 2, 1, 30, 32'd1, 32'd1));
    vecs.push_back(mk("ovf_rd", enc_r(3, 1, 2, 0, 0), 1, 32'h7FFFFFFF, 2, 1, 3, 0, 32'd1));
    vecs.push_back(mk("ovf_addi", enc_i(5, 3, 1, 1), 1, 32'h7FFFFFFF, 0, 0, 30, 32'd2, 32'd1));
    vecs.push_back(mk("ovf_sub", enc_r(3, 1, 2, 0, 1), 1, 32'h80000000, 2, 1, 30, 32'd3, 32'd1));
`else
    vecs.push_back(mk("ovf_add", enc_r(3, 1, 2, 0, 0), 1, 32'h7FFFFFFF, 2, 1, 3, 32'h80000000, 32'd1));
    vecs.push_back(mk("ovf_r30", enc_r(3, 1, 2, 0, 0), 1, 32'h7FFFFFFF, 2, 1, 30, 0, 32'd1));
    vecs.push_back(mk("ovf_addi", enc_i(5, 3, 1, 1), 1, 32'h7FFFFFFF, 0, 0, 3, 32'h80000000, 32'd1));
    vecs.push_back(mk("ovf_sub", enc_r(3, 1, 2, 0, 1), 1, 32'h80000000, 2, 1, 3, 32'h7FFFFFFF, 32'd1));
`endif

    // Reset state
    #2;
    check("rst_pc", address_imem, 32'd0);
    check("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check("rst_wren", {31'd0, wren}, 32'd0);

    foreach (vecs[k]) begin
      clear_all();
      rom[0] = vecs[k].instr;
      init_regs[vecs[k].ra] = vecs[k].va;
      init_regs[vecs[k].rb] = vecs[k].vb;
      start();
      repeat (3) @(negedge clock);
      check($sformatf("%s_reg", vecs[k].name), regs[vecs[k].chk], vecs[k].exp_val);
      check($sformatf("%s_pc", vecs[k].name), address_imem, vecs[k].exp_pc);
    end

    // addi, addi, add: one regfile write each EXEC cycle (every 3rd cycle)
    clear_all();
    rom[0] = enc_i(5, 1, 0, 5);
    rom[1] = enc_i(5, 2, 0, -3);
    rom[2] = enc_r(3, 1, 2, 0, 0);
    start();
    we_mask = '0;
    for (int c = 0; c < 9; c++) begin
      we_mask[c] = ctrl_writeEnable;
      @(negedge clock);
    end
    check("seq_we_mask", {22'd0, we_mask}, 32'b0_1001_0010_0);
    check("seq_r1", regs[1], 32'd5);
    check("seq_r2", regs[2], 32'hFFFFFFFD);
    check("seq_r3", regs[3], 32'd2);

    // addi r1=77; sw r1,4(r0); lw r4,4(r0) -- lw takes the extra MEM cycle
    clear_all();
    rom[0] = enc_i(5, 1, 0, 77);
    rom[1] = enc_i(7, 1, 0, 4);
    rom[2] = enc_i(8, 4, 0, 4);
    start();
    we_mask = '0; wren_mask = '0; st_addr = '0; st_data = '0;
    for (int c = 0; c < 10; c++) begin
      we_mask[c]   = ctrl_writeEnable;
      wren_mask[c] = wren;
      if (wren) begin
        st_addr = address_dmem;
        st_data = data;
      end
      @(negedge clock);
    end
    check("ls_wren_mask", {22'd0, wren_mask}, 32'b00_0010_0000);
    check("ls_we_mask", {22'd0, we_mask}, 32'b10_0000_0100);
    check("ls_st_addr", st_addr, 32'd4);
    check("ls_st_data", st_data, 32'd77);
    check("ls_r4", regs[4], 32'd77);
    check("ls_pc", address_imem, 32'd3);

    // jal 10; jr r31 back to 1; addi r5 at 1
    clear_all();
    rom[0]  = enc_j(3, 10);
    rom[10] = enc_i(4, 31, 0, 0);
    rom[1]  = enc_i(5, 5, 0, 1);
    start();
    repeat (3) @(negedge clock);
    check("call_pc", address_imem, 32'd10);
    check("call_r31", regs[31], 32'd1);
    repeat (3) @(negedge clock);
    check("ret_pc", address_imem, 32'd1);
    repeat (3) @(negedge clock);
    check("ret_r5", regs[5], 32'd1);

    // setx 9; bex 20 then setx 0; bex falls through
    clear_all();
    rom[0]  = enc_j(21, 9);
    rom[1]  = enc_j(22, 20);
    rom[20] = enc_j(21, 0);
    rom[21] = enc_j(22, 40);
    start();
    repeat (6) @(negedge clock);
    check("bex_seq_r30", regs[30], 32'd9);
    check("bex_seq_pc", address_imem, 32'd20);
    repeat (6) @(negedge clock);
    check("bex_fall_pc", address_imem, 32'd22);

    // Async reset in the middle of an addi EXEC: PC drops at once, no write lands
    clear_all();
    rom[0] = enc_j(1, 5);
    rom[5] = enc_i(5, 6, 0, 9);
    start();
    repeat (5) @(negedge clock);
    check("mid_pre_pc", address_imem, 32'd5);
    check("mid_pre_we", {31'd0, ctrl_writeEnable}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_pc", address_imem, 32'd0);
    check("mid_rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    @(negedge clock);
    check("mid_rst_r6", regs[6], 32'd0);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("mid_rerun_r6", regs[6], 32'd9);
    check("mid_rerun_pc", address_imem, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
